// File: rtl/decode_pkg.sv
// Shared decode types, opcode constants and the pure field decoder.
package decode_pkg;

  localparam int unsigned FIELD_MAX = 16;
  localparam int unsigned INST_MAX  = 32;

  // Decoded instruction; fields are sized for the largest supported config
  // and the low bits are used for the actual parameter set.
  typedef struct packed {
    logic [FIELD_MAX-1:0] opcode;
    logic [FIELD_MAX-1:0] opa;
    logic [FIELD_MAX-1:0] opb;
    logic [FIELD_MAX-1:0] dmaddr;
    logic [FIELD_MAX-1:0] dest;
    logic                 is_mem;
  } dec_t;

  // Low-w-bits-set mask.
  function automatic logic [INST_MAX-1:0] field_mask(input int unsigned w);
    return (INST_MAX'(1) << w) - INST_MAX'(1);
  endfunction

  // Memory opcode: all ones.
  function automatic logic [FIELD_MAX-1:0] op_mem(input int unsigned op_w);
    return FIELD_MAX'(field_mask(op_w));
  endfunction

  // No-source opcode: all ones minus one.
  function automatic logic [FIELD_MAX-1:0] op_nosrc(input int unsigned op_w);
    return op_mem(op_w) - FIELD_MAX'(1);
  endfunction

  // Split a raw instruction into its decoded fields.
  function automatic dec_t decode(input logic [INST_MAX-1:0] inst,
                                  input int unsigned inst_w,
                                  input int unsigned op_w,
                                  input int unsigned reg_w,
                                  input int unsigned addr_w);
    dec_t d;
    logic [INST_MAX-1:0] rmask;
    d        = '0;
    rmask    = field_mask(reg_w);
    d.opcode = FIELD_MAX'((inst >> (inst_w - op_w)) & field_mask(op_w));
    d.dest   = FIELD_MAX'(inst & rmask);
    d.is_mem = (d.opcode == op_mem(op_w));
    if (d.is_mem) begin
      d.dmaddr = FIELD_MAX'((inst >> (inst_w - op_w - addr_w)) & field_mask(addr_w));
    end else if (d.opcode != op_nosrc(op_w)) begin
      d.opa = FIELD_MAX'((inst >> (inst_w - op_w - reg_w)) & rmask);
      d.opb = FIELD_MAX'((inst >> (inst_w - op_w - 2 * reg_w)) & rmask);
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending bits with writeback bypass on all lookups.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned REG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_idx,
  input  logic             i_wb_en,
  input  logic [REG_W-1:0] i_wb_idx,
  input  logic             i_kill_en,
  input  logic [REG_W-1:0] i_kill_idx,
  input  logic [REG_W-1:0] i_ra_idx,
  input  logic [REG_W-1:0] i_rb_idx,
  input  logic [REG_W-1:0] i_rd_idx,
  output logic             o_ra_pend_c,
  output logic             o_rb_pend_c,
  output logic             o_rd_pend_c
);

  localparam int unsigned NREGS = 1 << REG_W;

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nxt;

  // Clears first so a same-cycle set of the same register wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_wb_en)   w_pend_nxt[i_wb_idx]   = 1'b0;
    if (i_kill_en) w_pend_nxt[i_kill_idx] = 1'b0;
    if (i_set_en)  w_pend_nxt[i_set_idx]  = 1'b1;
  end

  // Pending-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  // A register being written back this cycle is treated as ready.
  assign o_ra_pend_c = r_pend[i_ra_idx] && !(i_wb_en && (i_wb_idx == i_ra_idx));
  assign o_rb_pend_c = r_pend[i_rb_idx] && !(i_wb_en && (i_wb_idx == i_rb_idx));
  assign o_rd_pend_c = r_pend[i_rd_idx] && !(i_wb_en && (i_wb_idx == i_rd_idx));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with RAW/WAW scoreboard stall and valid/ready handshakes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INST_W = 13,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opcode,
  output logic [REG_W-1:0]  out_opa,
  output logic [REG_W-1:0]  out_opb,
  output logic [ADDR_W-1:0] out_dmaddr,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_is_mem,
  output logic [CNT_W-1:0]  stall_cnt
);

  dec_t              w_dec;
  logic              w_dec_unused;
  logic              w_is_nosrc;
  logic              w_chk_src;
  logic              w_ra_pend;
  logic              w_rb_pend;
  logic              w_rd_pend;
  logic              w_hazard;
  logic              w_accept;

  logic              r_out_valid;
  logic [OP_W-1:0]   r_out_opcode;
  logic [REG_W-1:0]  r_out_opa;
  logic [REG_W-1:0]  r_out_opb;
  logic [ADDR_W-1:0] r_out_dmaddr;
  logic [REG_W-1:0]  r_out_dest;
  logic              r_out_is_mem;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Field extraction and source-check qualification.
  assign w_dec        = decode(INST_MAX'(in_inst), INST_W, OP_W, REG_W, ADDR_W);
  assign w_dec_unused = ^w_dec;
  assign w_is_nosrc   = (w_dec.opcode == op_nosrc(OP_W));
  assign w_chk_src    = !w_dec.is_mem && !w_is_nosrc;

  decode_scoreboard #(
    .REG_W (REG_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_en    (w_accept),
    .i_set_idx   (w_dec.dest[REG_W-1:0]),
    .i_wb_en     (wb_valid),
    .i_wb_idx    (wb_dest),
    .i_kill_en   (flush && r_out_valid),
    .i_kill_idx  (r_out_dest),
    .i_ra_idx    (w_dec.opa[REG_W-1:0]),
    .i_rb_idx    (w_dec.opb[REG_W-1:0]),
    .i_rd_idx    (w_dec.dest[REG_W-1:0]),
    .o_ra_pend_c (w_ra_pend),
    .o_rb_pend_c (w_rb_pend),
    .o_rd_pend_c (w_rd_pend)
  );

  // Hazard and handshake.
  assign w_hazard = (w_chk_src && (w_ra_pend || w_rb_pend)) || w_rd_pend;
  assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  // Output register: load on accept, drop on flush or downstream take, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_opcode <= '0;
      r_out_opa    <= '0;
      r_out_opb    <= '0;
      r_out_dmaddr <= '0;
      r_out_dest   <= '0;
      r_out_is_mem <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= w_dec.opcode[OP_W-1:0];
      r_out_opa    <= w_dec.opa[REG_W-1:0];
      r_out_opb    <= w_dec.opb[REG_W-1:0];
      r_out_dmaddr <= w_dec.dmaddr[ADDR_W-1:0];
      r_out_dest   <= w_dec.dest[REG_W-1:0];
      r_out_is_mem <= w_dec.is_mem;
    end else if (flush || out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Saturating count of cycles where a presented instruction is held off by a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_opcode = r_out_opcode;
  assign out_opa    = r_out_opa;
  assign out_opb    = r_out_opb;
  assign out_dmaddr = r_out_dmaddr;
  assign out_dest   = r_out_dest;
  assign out_is_mem = r_out_is_mem;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed check of decode_stage against a behavioural model.
module tb_decode_stage;

  localparam int INST_W = 13;
  localparam int OP_W   = 4;
  localparam int REG_W  = 3;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;
  localparam int NREGS  = 8;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INST_W-1:0] in_inst = '0;
  logic              flush = 1'b0;
  logic              wb_valid = 1'b0;
  logic [REG_W-1:0]  wb_dest = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OP_W-1:0]   out_opcode;
  logic [REG_W-1:0]  out_opa;
  logic [REG_W-1:0]  out_opb;
  logic [ADDR_W-1:0] out_dmaddr;
  logic [REG_W-1:0]  out_dest;
  logic              out_is_mem;
  logic [CNT_W-1:0]  stall_cnt;

  decode_stage #(
    .INST_W (INST_W), .OP_W (OP_W), .REG_W (REG_W), .ADDR_W (ADDR_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_inst (in_inst),
    .flush (flush), .wb_valid (wb_valid), .wb_dest (wb_dest),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_opcode (out_opcode), .out_opa (out_opa), .out_opb (out_opb),
    .out_dmaddr (out_dmaddr), .out_dest (out_dest), .out_is_mem (out_is_mem),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit last_rdy;

  // Model state: pending set, held instruction, stall count.
  bit m_pend [NREGS];
  bit m_hv;
  int m_op, m_a, m_b, m_addr, m_d;
  bit m_mem;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode by plain arithmetic on the instruction value.
  function automatic void mdec(input int inst, output int op, output int a, output int b,
                               output int addr, output int d, output bit mem, output bit nos);
    int rest;
    op   = inst / (1 << (INST_W - OP_W));
    rest = inst % (1 << (INST_W - OP_W));
    a    = rest / (NREGS * NREGS);
    b    = (rest / NREGS) % NREGS;
    d    = rest % NREGS;
    addr = rest / (1 << (INST_W - OP_W - ADDR_W));
    mem  = (op == (1 << OP_W) - 1);
    nos  = (op == (1 << OP_W) - 2);
    if (mem || nos) begin a = 0; b = 0; end
    if (!mem) addr = 0;
  endfunction

  function automatic bit peff(input int r, input bit wbv, input int wbd);
    return m_pend[r] && !(wbv && wbd == r);
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_hv = 0; m_op = 0; m_a = 0; m_b = 0; m_addr = 0; m_d = 0; m_mem = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_hv));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (m_hv) begin
      check("out_opcode", 32'(out_opcode), 32'(m_op));
      check("out_opa",    32'(out_opa),    32'(m_a));
      check("out_opb",    32'(out_opb),    32'(m_b));
      check("out_dmaddr", 32'(out_dmaddr), 32'(m_addr));
      check("out_dest",   32'(out_dest),   32'(m_d));
      check("out_is_mem", 32'(out_is_mem), 32'(m_mem));
    end
  endtask

  // One clock: check state, drive inputs, check in_ready, advance the model.
  task automatic step(input bit iv, input int inst, input bit fl, input bit wbv,
                      input int wbd, input bit ordy);
    int op, a, b, ad, d;
    bit mem, nos, haz, rdy, acc;
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    in_inst   = INST_W'(inst);
    flush     = fl;
    wb_valid  = wbv;
    wb_dest   = REG_W'(wbd);
    out_ready = ordy;
    #1;
    mdec(inst, op, a, b, ad, d, mem, nos);
    haz = (!mem && !nos && (peff(a, wbv, wbd) || peff(b, wbv, wbd))) || peff(d, wbv, wbd);
    rdy = (!m_hv || ordy) && !haz && !fl;
    check("in_ready", 32'(in_ready), 32'(rdy));
    last_rdy = in_ready;
    acc = iv && rdy;
    if (iv && haz && m_cnt < CNT_MAX) m_cnt++;
    if (wbv) m_pend[wbd] = 1'b0;
    if (fl && m_hv) m_pend[m_d] = 1'b0;
    if (acc) m_pend[d] = 1'b1;
    if (acc) begin
      m_hv = 1; m_op = op; m_a = a; m_b = b; m_addr = ad; m_d = d; m_mem = mem;
    end else if (fl || ordy) begin
      m_hv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_fields", {out_opcode, out_opa, out_opb, out_dmaddr, out_dest, out_is_mem}, 32'd0);
    model_reset();
    in_valid = 0; in_inst = '0; flush = 0; wb_valid = 0; wb_dest = '0; out_ready = 0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Plain ALU op, then memory op.
    step(1, 'h0253, 0, 0, 0, 1);
    check("d1_valid", 32'(out_valid), 32'd1);
    check("d1_opcode", 32'(out_opcode), 32'd1);
    check("d1_opa", 32'(out_opa), 32'd1);
    check("d1_opb", 32'(out_opb), 32'd2);
    check("d1_dest", 32'(out_dest), 32'd3);
    check("d1_dmaddr", 32'(out_dmaddr), 32'd0);
    step(1, 'h1EA6, 0, 0, 0, 1);
    check("d2_is_mem", 32'(out_is_mem), 32'd1);
    check("d2_dmaddr", 32'(out_dmaddr), 32'd5);
    check("d2_opab", {out_opa, out_opb}, 32'd0);
    check("d2_dest", 32'(out_dest), 32'd6);

    // RAW on r3 stalls until writeback, which bypasses in the same cycle.
    for (int i = 0; i < 3; i++) begin
      step(1, 'h02C4, 0, 0, 0, 1);
      check("raw_stall_rdy", 32'(last_rdy), 32'd0);
    end
    check("raw_stall_cnt", 32'(stall_cnt), 32'd3);
    step(1, 'h02C4, 0, 1, 3, 1);
    check("bypass_rdy", 32'(last_rdy), 32'd1);
    check("bypass_cnt", 32'(stall_cnt), 32'd3);

    // Downstream backpressure holds the outputs.
    for (int i = 0; i < 3; i++) begin
      step(1, 'h0001, 0, 0, 0, 0);
      check("hold_opa", 32'(out_opa), 32'd3);
      check("hold_dest", 32'(out_dest), 32'd4);
    end
    step(1, 'h0001, 0, 0, 0, 1);
    check("release_rdy", 32'(last_rdy), 32'd1);

    // Flush drops the held instruction and frees its destination.
    do_reset();
    step(1, 'h0253, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("flush_valid", 32'(out_valid), 32'd0);
    step(1, 'h02C4, 0, 0, 0, 1);
    check("flush_free_rdy", 32'(last_rdy), 32'd1);

    // Counter saturation, then reset in the middle of a stall.
    do_reset();
    step(1, 'h0253, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 'h02C4, 0, 0, 0, 1);
    check("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    do_reset();
    step(1, 'h02C4, 0, 0, 0, 1);
    check("post_rst_rdy", 32'(last_rdy), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r, op, inst;
      r = int'($urandom_range(0, 9));
      if (r < 2)      op = 15;
      else if (r < 3) op = 14;
      else            op = int'($urandom_range(0, 13));
      inst = op * 512 + int'($urandom_range(0, 511));
      step($urandom_range(0, 3) != 0, inst, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
      if (n % 700 == 699) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction decode stage (D of F-D-X-M-W). It splits each instruction into opcode, source operands, data-memory address and destination. It tracks in-flight destinations in a register scoreboard and stalls on RAW/WAW hazards. Valid/ready handshakes on both sides connect it between fetch and execute, and writeback feedback releases scoreboard entries.

## Interface
Parameters:
- `INST_W`, 13, instruction width; must equal `OP_W + 3*REG_W`.
- `OP_W`, 4, opcode field width, at `[INST_W-1 -: OP_W]`.
- `REG_W`, 3, register index width; `NREGS = 2**REG_W`.
- `ADDR_W`, 4, data-memory address width; must be ≤ `2*REG_W`.
- `CNT_W`, 16, stall counter width.

Ports (clk, reset first):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch presents `in_inst`.
- `in_ready` out 1: decode accepts this cycle.
- `in_inst` in `INST_W`: raw instruction.
- `flush` in 1: synchronous kill of the held instruction.
- `wb_valid` in 1: writeback retires a destination.
- `wb_dest` in `REG_W`: register being retired.
- `out_valid` out 1: decoded instruction held.
- `out_ready` in 1: execute accepts.
- `out_opcode` out `OP_W`.
- `out_opa`, `out_opb` out `REG_W`: source operands.
- `out_dmaddr` out `ADDR_W`: data-memory address.
- `out_dest` out `REG_W`: destination register.
- `out_is_mem` out 1: opcode is `OP_MEM`.
- `stall_cnt` out `CNT_W`: saturating count of hazard-stall cycles.

## Operation
- Fields: opcode `[INST_W-1 -: OP_W]`, opa `[INST_W-OP_W-1 -: REG_W]`, opb next `REG_W` bits, dest `[REG_W-1:0]`.
- `OP_MEM` = all ones:
  - dmaddr = `[INST_W-OP_W-1 -: ADDR_W]`.
  - opa = opb = 0.
  - No source hazard check.
- `OP_NOSRC` = all ones minus 1: opa = opb = dmaddr = 0; no source hazard check.
- All other opcodes: dmaddr = 0; opa and opb are checked against the scoreboard.
- Scoreboard: one pending bit per register. Every accepted instruction sets its dest bit. `wb_valid` clears the bit at `wb_dest`.
- Hazard: a checked source or the dest is pending. A same-cycle `wb_valid` to that register counts as not pending (writeback bypass).
- `in_ready = (!out_valid || out_ready) && !hazard && !flush`.
- Set and clear of the same register in one cycle: set wins.
- `stall_cnt` increments on each cycle with `in_valid && hazard` and saturates at all-ones.
- `flush`:
  - Drops the held instruction: `out_valid` goes to 0 next cycle.
  - Clears that instruction's dest bit unless the same cycle also accepts a new one (impossible, since `in_ready` = 0) or a `wb_valid` targets it.
  - `flush` with `out_valid` = 0 has no effect on the scoreboard.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Outputs are registered, except `in_ready`, which is combinational from `in_inst`, `wb_*`, `out_ready`, `flush` and state.
- While `out_valid && !out_ready`, all `out_*` are held stable.
- Back-to-back accepts are sustained at 1 per cycle when there is no hazard and `out_ready` = 1.
- Reset (asynchronous, mid-operation included): `out_valid` = 0, all `out_*` = 0, scoreboard = 0, `stall_cnt` = 0.
- After reset, `in_ready` = 1 for any non-hazard instruction.

## Structure
- Package `decode_pkg`:
  - `OP_MEM` and `OP_NOSRC` as functions of `OP_W`.
  - A typedef'd decoded-instruction struct (opcode, opa, opb, dmaddr, dest, is_mem).
  - A pure `decode()` function.
- Sub-module `decode_scoreboard`: `NREGS` pending bits, set/clear ports, two source-lookup ports plus one dest-lookup port with writeback bypass.
- Top level: field extraction, handshake, output register, stall counter.

## Test plan
- Reset, then `in_inst` = 0x0253 (op 1, a1, b2, d3) -> next cycle: `out_valid` = 1, opcode 1, opa 1, opb 2, dest 3, dmaddr 0; r3 pending.
- 0x1EA6 (OP_MEM, addr 5, d6) -> `out_is_mem` = 1, dmaddr 5, opa = opb = 0, dest 6.
- 0x0253 then 0x02C4 (reads r3) -> `in_ready` = 0 and `stall_cnt` increments each cycle until `wb_valid`/`wb_dest` = 3. The same cycle as the writeback, `in_ready` = 1 (bypass).
- `out_ready` = 0 for 3 cycles with a held instruction -> outputs stable, `in_ready` = 0; release -> next instruction accepted next cycle.
- `flush` with 0x0253 held -> `out_valid` 0 next cycle, r3 no longer pending; 0x02C4 accepted without stall.
- Assert `rst_n` low mid-stall -> all outputs, scoreboard and `stall_cnt` = 0 immediately; force `stall_cnt` to all-ones and stall -> it holds at saturation.
